// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM encoding, reset cause codes and
// the width of the reset event counter.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_POR_HOLD = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_RUN      = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'd0,
    CAUSE_BUTTON = 2'd1,
    CAUSE_SOFT   = 2'd2,
    CAUSE_WDT    = 2'd3
  } reset_cause_t;

  localparam int COUNT_W = 8;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (value == {COUNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/reset_debouncer.sv
// Push-button front end: synchroniser, stability counter and a one-cycle
// pulse on each rising edge of the debounced level.
module reset_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  output logic rise_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   level_reg;
  logic                   rise_reg;
  logic                   sync_bit;
  logic                   differ;
  logic                   accept;

  assign sync_bit = sync_reg[SYNC_STAGES-1];
  assign differ   = (sync_bit != level_reg);
  // The level only moves on the last of an unbroken run of differing samples.
  assign accept   = differ && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg[0] <= button_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      rise_reg <= accept && sync_bit;
      if (accept) begin
        level_reg <= sync_bit;
        cnt_reg   <= '0;
      end else if (differ) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign rise_o = rise_reg;

endmodule

// File: rtl/reset_sequencer.sv
// Staggered multi-channel reset generator with button, software and watchdog
// re-entry, last-cause reporting and a saturating reset event counter.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int POR_CYCLES      = 20,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGGER_CYCLES  = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int WDT_TIMEOUT     = 2 ** 24,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    button_i,
  input  logic                    soft_reset_req_i,
  input  logic                    wdt_enable_i,
  input  logic                    wdt_kick_i,
  output logic [NUM_CHANNELS-1:0] reset_o,
  output logic                    ready_o,
  output logic [1:0]              reset_cause_o,
  output logic [COUNT_W-1:0]      reset_count_o
);

  localparam int HOLD_MAX = (POR_CYCLES > HOLD_CYCLES) ? POR_CYCLES : HOLD_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int STG_END  = (NUM_CHANNELS - 1) * STAGGER_CYCLES + 1;
  localparam int STG_W    = $clog2(STG_END + 1);
  localparam int WDT_W    = $clog2(WDT_TIMEOUT);

  localparam logic [HOLD_W-1:0] POR_LAST  = HOLD_W'(POR_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STG_END);
  localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'(WDT_TIMEOUT - 1);

  seq_state_t                state_reg, state_next;
  logic [HOLD_W-1:0]         hold_cnt_reg, hold_cnt_next;
  logic [STG_W-1:0]          stg_cnt_reg, stg_cnt_next;
  logic [WDT_W-1:0]          wdt_cnt_reg, wdt_cnt_next;
  reset_cause_t              cause_reg, cause_next;
  logic [COUNT_W-1:0]        count_reg, count_next;
  logic [NUM_CHANNELS-1:0]   chan_reg, chan_next;
  logic                      ready_reg, ready_next;

  logic                      button_rise;
  logic                      wdt_fire;
  logic                      trig_window;
  logic                      trig_any;
  reset_cause_t              trig_cause;
  logic                      hold_all_next;
  logic                      releasing_next;

  reset_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .button_i (button_i),
    .rise_o   (button_rise)
  );

  assign wdt_fire    = (state_reg == ST_RUN) && wdt_enable_i && !wdt_kick_i &&
                       (wdt_cnt_reg == WDT_LAST);
  assign trig_window = (state_reg == ST_RELEASE) || (state_reg == ST_RUN);
  assign trig_any    = trig_window && (button_rise || wdt_fire || soft_reset_req_i);

  always_comb begin
    trig_cause = CAUSE_SOFT;
    if (button_rise) begin
      trig_cause = CAUSE_BUTTON;
    end else if (wdt_fire) begin
      trig_cause = CAUSE_WDT;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_POR_HOLD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and sequencing counters
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    stg_cnt_next  = stg_cnt_reg;
    case (state_reg)
      ST_POR_HOLD: begin
        if (hold_cnt_reg == POR_LAST) begin
          state_next    = ST_RELEASE;
          hold_cnt_next = '0;
          stg_cnt_next  = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      ST_ASSERT: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          state_next    = ST_RELEASE;
          hold_cnt_next = '0;
          stg_cnt_next  = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (trig_any) begin
          state_next    = ST_ASSERT;
          hold_cnt_next = '0;
        end else if (stg_cnt_reg == STG_LAST) begin
          state_next = ST_RUN;
        end else begin
          stg_cnt_next = stg_cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        if (trig_any) begin
          state_next    = ST_ASSERT;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = ST_POR_HOLD;
        hold_cnt_next = '0;
        stg_cnt_next  = '0;
      end
    endcase
  end

  // The watchdog only accumulates while the system is running with it enabled.
  always_comb begin
    wdt_cnt_next = '0;
    if ((state_reg == ST_RUN) && wdt_enable_i && !trig_any) begin
      wdt_cnt_next = wdt_kick_i ? '0 : wdt_cnt_reg + 1'b1;
    end
  end

  // Output decode, computed from the next state so every output is a flop.
  always_comb begin
    ready_next = (state_next == ST_RUN);
    cause_next = cause_reg;
    count_next = count_reg;
    if (trig_any) begin
      cause_next = trig_cause;
      count_next = sat_inc(count_reg);
    end
  end

  assign hold_all_next  = (state_next == ST_POR_HOLD) || (state_next == ST_ASSERT);
  assign releasing_next = (state_next == ST_RELEASE);

  // Channel i stays asserted until the shared stagger count passes i*STAGGER_CYCLES.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    localparam logic [STG_W-1:0] REL_AT = STG_W'(gi * STAGGER_CYCLES);
    assign chan_next[gi] = hold_all_next || (releasing_next && (stg_cnt_next <= REL_AT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_reg <= '0;
      stg_cnt_reg  <= '0;
      wdt_cnt_reg  <= '0;
      cause_reg    <= CAUSE_POR;
      count_reg    <= '0;
      chan_reg     <= '1;
      ready_reg    <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      stg_cnt_reg  <= stg_cnt_next;
      wdt_cnt_reg  <= wdt_cnt_next;
      cause_reg    <= cause_next;
      count_reg    <= count_next;
      chan_reg     <= chan_next;
      ready_reg    <= ready_next;
    end
  end

  assign reset_o       = chan_reg;
  assign ready_o       = ready_reg;
  assign reset_cause_o = cause_reg;
  assign reset_count_o = count_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised bench for reset_sequencer; a timeline model (edges since the last
// reset start, sample history, idle time) predicts every output each cycle.
module tb_reset_sequencer;

  localparam int N      = 3;
  localparam int POR_C  = 20;
  localparam int HOLD_C = 8;
  localparam int STG_C  = 4;
  localparam int DEB_C  = 5;
  localparam int WDT_C  = 100;
  localparam int SYNC_C = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         button_i = 1'b0;
  logic         soft_reset_req_i = 1'b0;
  logic         wdt_enable_i = 1'b0;
  logic         wdt_kick_i = 1'b0;
  logic [N-1:0] reset_o;
  logic         ready_o;
  logic [1:0]   reset_cause_o;
  logic [7:0]   reset_count_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: m_e = edges since the current hold began, m_h = its length.
  int m_e, m_h, m_cause, m_count, m_idle, n_trig;
  bit m_level, m_pend;
  bit raw_q[$];
  int btn_left = 0;
  bit found;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CHANNELS    (N),
    .POR_CYCLES      (POR_C),
    .HOLD_CYCLES     (HOLD_C),
    .STAGGER_CYCLES  (STG_C),
    .DEBOUNCE_CYCLES (DEB_C),
    .WDT_TIMEOUT     (WDT_C),
    .SYNC_STAGES     (SYNC_C)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .button_i         (button_i),
    .soft_reset_req_i (soft_reset_req_i),
    .wdt_enable_i     (wdt_enable_i),
    .wdt_kick_i       (wdt_kick_i),
    .reset_o          (reset_o),
    .ready_o          (ready_o),
    .reset_cause_o    (reset_cause_o),
    .reset_count_o    (reset_count_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_e = 0;
    m_h = POR_C;
    m_cause = 0;
    m_count = 0;
    m_idle = 0;
    m_level = 1'b0;
    m_pend = 1'b0;
    raw_q.delete();
    for (int k = 0; k < SYNC_C + DEB_C; k++) raw_q.push_back(1'b0);
  endtask

  task automatic model_edge();
    bit in_run, can_trig, flip, btn_t, wdt_t;
    in_run   = (m_e >= m_h + 2 + (N - 1) * STG_C);
    can_trig = (m_e >= m_h);
    // Button: accepted once DEB_C consecutive synchronised samples disagree.
    raw_q.push_front(button_i);
    void'(raw_q.pop_back());
    flip = 1'b1;
    for (int k = SYNC_C; k < SYNC_C + DEB_C; k++) begin
      if (raw_q[k] == m_level) flip = 1'b0;
    end
    btn_t  = m_pend;
    m_pend = flip && !m_level;
    if (flip) m_level = !m_level;
    wdt_t = in_run && wdt_enable_i && !wdt_kick_i && (m_idle == WDT_C - 1);
    if (can_trig && (btn_t || wdt_t || soft_reset_req_i)) begin
      m_cause = btn_t ? 1 : (wdt_t ? 3 : 2);
      m_count = (m_count < 255) ? m_count + 1 : 255;
      m_e = 0;
      m_h = HOLD_C;
      m_idle = 0;
      n_trig++;
      $display("cycle %0d: reset trigger cause=%0d count=%0d", cyc, m_cause, m_count);
    end else begin
      m_e++;
      if (in_run && wdt_enable_i) m_idle = wdt_kick_i ? 0 : m_idle + 1;
      else m_idle = 0;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_rst;
    for (int i = 0; i < N; i++) exp_rst[i] = (m_e < m_h + 1 + i * STG_C);
    check_eq("reset_o", 32'(reset_o), 32'(exp_rst));
    check_eq("ready_o", 32'(ready_o), 32'(m_e >= m_h + 2 + (N - 1) * STG_C));
    check_eq("cause", 32'(reset_cause_o), m_cause);
    check_eq("count", 32'(reset_count_o), m_count);
  endtask

  task automatic check_in_reset(input string tag);
    check_eq({tag, "_reset_o"}, 32'(reset_o), 32'h7);
    check_eq({tag, "_ready"}, 32'(ready_o), 32'h0);
    check_eq({tag, "_cause"}, 32'(reset_cause_o), 32'h0);
    check_eq({tag, "_count"}, 32'(reset_count_o), 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_outputs();
    soft_reset_req_i = 1'b0;
    wdt_kick_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_trig = 0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_in_reset("por_low");
    end
    reset = 1'b1;
    $display("cycle %0d: power-on reset released", cyc);
    repeat (40) step();

    // Software request
    soft_reset_req_i = 1'b1;
    step();
    repeat (40) step();

    // Button: short glitch, long press, release, second press
    repeat (3) begin button_i = 1'b1; step(); end
    button_i = 1'b0;
    repeat (20) step();
    button_i = 1'b1;
    repeat (40) step();
    button_i = 1'b0;
    repeat (40) step();
    button_i = 1'b1;
    repeat (40) step();
    button_i = 1'b0;
    repeat (30) step();

    // Watchdog: regular kicks, starvation, disable mid-count
    wdt_enable_i = 1'b1;
    repeat (8) begin
      repeat (49) step();
      wdt_kick_i = 1'b1;
      step();
    end
    repeat (150) step();
    wdt_kick_i = 1'b1;
    step();
    repeat (60) step();
    wdt_enable_i = 1'b0;
    repeat (120) step();
    wdt_enable_i = 1'b1;
    wdt_kick_i = 1'b1;
    step();
    repeat (60) step();
    wdt_enable_i = 1'b0;
    repeat (10) step();

    // Soft request on the same edge as a debounced button edge
    button_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (m_pend) begin
        soft_reset_req_i = 1'b1;
        found = 1'b1;
        step();
      end
    end
    check_eq("simul_seen", 32'(found), 32'h1);
    check_eq("simul_cause", 32'(reset_cause_o), 32'h1);
    repeat (2) step();
    soft_reset_req_i = 1'b1;
    step();
    repeat (40) step();
    button_i = 1'b0;
    repeat (20) step();

    // Random traffic
    wdt_enable_i = 1'b1;
    repeat (3000) begin
      if (btn_left == 0) begin
        button_i = ~button_i;
        btn_left = button_i ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 80));
      end
      btn_left--;
      soft_reset_req_i = ($urandom_range(0, 59) == 0);
      wdt_kick_i = ($urandom_range(0, 44) == 0);
      if ($urandom_range(0, 299) == 0) wdt_enable_i = ~wdt_enable_i;
      step();
    end
    button_i = 1'b0;
    wdt_enable_i = 1'b0;
    repeat (60) step();

    // Asynchronous reset while channel 1 is still held in release
    soft_reset_req_i = 1'b1;
    step();
    for (int k = 0; k < 20 && m_e != HOLD_C + 2; k++) step();
    check_eq("mid_release_bits", 32'(reset_o), 32'h6);
    #2 reset = 1'b0;
    #1;
    check_in_reset("async_mid");
    $display("cycle %0d: async reset asserted during release", cyc);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) step();

    // Count saturation, each trigger landing while channel 1 is still asserted
    repeat (265) begin
      soft_reset_req_i = 1'b1;
      step();
      repeat (9) step();
    end
    check_eq("count_sat", 32'(reset_count_o), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
